// File: rtl/seg_reduce_pipe.sv
// seg_reduce_pipe: pipelined segmented inclusive scan (sum or signed max) over N lanes.
// One beat per cycle; a single global advance enable stalls every stage together.
module seg_reduce_pipe #(
   parameter int N = 32,
   parameter int W = 32,
   localparam int LOG2N = $clog2(N),
   localparam int OW = W + LOG2N
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_seg_end,
   input  logic            in_mode,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N*OW-1:0] out_data,
   output logic [N-1:0]    out_mask,
   output logic            out_mode,
   output logic            busy
);
   localparam int NS = LOG2N + 1;

   typedef logic [OW-1:0] lane_t;

   lane_t         x_r    [NS][N];
   lane_t         x_s    [NS][N];
   logic [N-1:0]  f_r    [NS];
   logic [N-1:0]  f_s    [NS];
   logic [N-1:0]  mask_r [NS];
   logic [N-1:0]  mask_s [NS];
   logic [NS-1:0] mode_r;
   logic [NS-1:0] mode_s;
   logic [NS-1:0] valid_r;
   logic [NS-1:0] valid_s;
   logic          adv_s;

   function automatic lane_t op(input logic max_mode, input lane_t a, input lane_t b);
      lane_t r;
      if (max_mode) begin
         r = ($signed(a) > $signed(b)) ? a : b;
      end else begin
         r = a + b;
      end
      return r;
   endfunction

   assign adv_s    = !(valid_r[NS-1] && !out_ready);
   assign in_ready = adv_s;

   // Next contents of every stage: S0 loads the input beat, each later stage does one scan step.
   always_comb begin
      int d;
      int src;
      x_s     = x_r;
      f_s     = f_r;
      mask_s  = mask_r;
      mode_s  = mode_r;
      valid_s = valid_r;
      d       = 0;
      src     = 0;

      for (int i = 0; i < N; i++) begin
         x_s[0][i] = {{LOG2N{in_data[i*W + W - 1]}}, in_data[i*W +: W]};
      end
      f_s[0]     = {in_seg_end[N-2:0], 1'b1};
      mask_s[0]  = in_seg_end | {1'b1, {(N-1){1'b0}}};
      mode_s[0]  = in_mode;
      valid_s[0] = in_valid;

      for (int k = 1; k < NS; k++) begin
         d = 1 << (k - 1);
         for (int i = 0; i < N; i++) begin
            // Clamped source index keeps the lane i-d lookup in range for lanes below d.
            src = (i >= d) ? (i - d) : i;
            if ((i >= d) && !f_r[k-1][i]) begin
               x_s[k][i] = op(mode_r[k-1], x_r[k-1][src], x_r[k-1][i]);
               f_s[k][i] = f_r[k-1][src];
            end else begin
               x_s[k][i] = x_r[k-1][i];
               f_s[k][i] = f_r[k-1][i];
            end
         end
         mask_s[k]  = mask_r[k-1];
         mode_s[k]  = mode_r[k-1];
         valid_s[k] = valid_r[k-1];
      end
   end

   // Pipeline registers: all stages advance together or all hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NS; k++) begin
            for (int i = 0; i < N; i++) begin
               x_r[k][i] <= {OW{1'b0}};
            end
            f_r[k]    <= {N{1'b0}};
            mask_r[k] <= {N{1'b0}};
         end
         mode_r  <= {NS{1'b0}};
         valid_r <= {NS{1'b0}};
      end else if (adv_s) begin
         x_r     <= x_s;
         f_r     <= f_s;
         mask_r  <= mask_s;
         mode_r  <= mode_s;
         valid_r <= valid_s;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_out
      assign out_data[i*OW +: OW] = x_r[NS-1][i];
   end

   assign out_valid = valid_r[NS-1];
   assign out_mask  = mask_r[NS-1];
   assign out_mode  = mode_r[NS-1];
   assign busy      = |valid_r;

endmodule

// File: tb/tb_seg_reduce_pipe.sv
// Bench for seg_reduce_pipe: directed N=8/W=8 scenarios plus a randomized N=32/W=32 stream
// checked against a lane-by-lane segmented scan model.
module tb_seg_reduce_pipe;
   localparam int N8 = 8, W8 = 8, OW8 = 11;
   localparam int N32 = 32, W32 = 32, OW32 = 37;

   logic clk;
   logic rst_n;

   logic              in_valid8, in_ready8, in_mode8, out_valid8, out_ready8, out_mode8, busy8;
   logic [N8*W8-1:0]  in_data8;
   logic [N8-1:0]     in_seg_end8, out_mask8;
   logic [N8*OW8-1:0] out_data8;

   logic                in_valid32, in_ready32, in_mode32, out_valid32, out_ready32, out_mode32, busy32;
   logic [N32*W32-1:0]  in_data32;
   logic [N32-1:0]      in_seg_end32, out_mask32;
   logic [N32*OW32-1:0] out_data32;

   int checks;
   int failures;

   typedef longint lanes_t [32];
   typedef struct packed {
      logic [N8*OW8-1:0] data;
      logic [N8-1:0]     mask;
      logic              mode;
   } beat8_t;
   typedef struct packed {
      logic [N32*OW32-1:0] data;
      logic [N32-1:0]      mask;
      logic                mode;
   } beat32_t;

   seg_reduce_pipe #(.N(N8), .W(W8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .in_data(in_data8), .in_seg_end(in_seg_end8), .in_mode(in_mode8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
      .out_mask(out_mask8), .out_mode(out_mode8), .busy(busy8));

   seg_reduce_pipe #(.N(N32), .W(W32)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
      .in_data(in_data32), .in_seg_end(in_seg_end32), .in_mode(in_mode32),
      .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32),
      .out_mask(out_mask32), .out_mode(out_mode32), .busy(busy32));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Walk back to the segment start, then fold the operator forward up to lane j.
   function automatic longint ref_lane(input lanes_t v, input logic [31:0] se, input logic mode, input int j);
      int s;
      longint acc;
      s = j;
      while (s > 0 && se[s-1] == 1'b0) s--;
      acc = v[s];
      for (int k = s + 1; k <= j; k++) begin
         if (mode) acc = (v[k] > acc) ? v[k] : acc;
         else      acc = acc + v[k];
      end
      return acc;
   endfunction

   function automatic beat8_t build_exp8(input logic [N8*W8-1:0] d, input logic [7:0] se, input logic m);
      lanes_t v;
      beat8_t b;
      for (int i = 0; i < 32; i++) v[i] = 0;
      for (int i = 0; i < N8; i++) v[i] = longint'($signed(d[i*W8 +: W8]));
      for (int j = 0; j < N8; j++) b.data[j*OW8 +: OW8] = 11'(ref_lane(v, {24'd0, se}, m, j));
      b.mask = se | 8'h80;
      b.mode = m;
      return b;
   endfunction

   function automatic beat32_t build_exp32(input logic [N32*W32-1:0] d, input logic [31:0] se, input logic m);
      lanes_t v;
      beat32_t b;
      for (int i = 0; i < N32; i++) v[i] = longint'($signed(d[i*W32 +: W32]));
      for (int j = 0; j < N32; j++) b.data[j*OW32 +: OW32] = 37'(ref_lane(v, se, m, j));
      b.mask = se | 32'h8000_0000;
      b.mode = m;
      return b;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid8 = 1'b0; in_data8 = '0; in_seg_end8 = '0; in_mode8 = 1'b0; out_ready8 = 1'b1;
      in_valid32 = 1'b0; in_data32 = '0; in_seg_end32 = '0; in_mode32 = 1'b0; out_ready32 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++; if (in_ready8 !== 1'b1) begin failures++; $display("FAIL reset_in_ready8 got %b want 1", in_ready8); end
      checks++; if (out_valid8 !== 1'b0) begin failures++; $display("FAIL reset_out_valid8 got %b want 0", out_valid8); end
      checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy8 got %b want 0", busy8); end
      checks++; if (out_data8 !== '0) begin failures++; $display("FAIL reset_out_data8 got %h want 0", out_data8); end
      checks++; if (out_mask8 !== 8'h00 || out_mode8 !== 1'b0) begin failures++; $display("FAIL reset_mask_mode8 got %h/%b want 00/0", out_mask8, out_mode8); end
      checks++; if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0 || busy32 !== 1'b0) begin failures++; $display("FAIL reset_ctrl32 got rdy=%b vld=%b busy=%b want 1/0/0", in_ready32, out_valid32, busy32); end
      checks++; if (out_data32 !== '0 || out_mask32 !== 32'h0 || out_mode32 !== 1'b0) begin failures++; $display("FAIL reset_out32 got mask=%h mode=%b want zero outputs", out_mask32, out_mode32); end
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin failures++; $display("FAIL post_reset8 got rdy=%b vld=%b want 1/0", in_ready8, out_valid8); end
   endtask

   task automatic test_directed_scans();
      int d [2][8];
      int e [2][8];
      logic [7:0] se_tab [2];
      logic [7:0] emask [2];
      logic md [2];
      int lat;
      d = '{'{1, 2, 3, 4, 5, 6, 7, 8}, '{-3, 5, -1, 2, -8, -7, -6, -128}};
      e = '{'{1, 3, 6, 10, 5, 11, 18, 26}, '{-3, 5, 5, 2, 2, -7, -6, -6}};
      se_tab = '{8'b1000_1000, 8'b0001_0100};
      emask  = '{8'b1000_1000, 8'b1001_0100};
      md     = '{1'b0, 1'b1};
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         out_ready8 = 1'b1;
         for (int i = 0; i < N8; i++) in_data8[i*W8 +: W8] = 8'(d[c][i]);
         in_seg_end8 = se_tab[c];
         in_mode8 = md[c];
         in_valid8 = 1'b1;
         #1;
         checks++; if (in_ready8 !== 1'b1) begin failures++; $display("FAIL directed%0d_in_ready got %b want 1", c, in_ready8); end
         lat = 0;
         do begin
            @(negedge clk);
            in_valid8 = 1'b0;
            lat++;
         end while (out_valid8 !== 1'b1 && lat < 20);
         checks++; if (lat != 4) begin failures++; $display("FAIL directed%0d_latency got %0d want 4", c, lat); end
         for (int i = 0; i < N8; i++) begin
            checks++;
            if (out_data8[i*OW8 +: OW8] !== 11'(e[c][i])) begin
               failures++;
               $display("FAIL directed%0d_lane%0d got %0d want %0d", c, i, $signed(out_data8[i*OW8 +: OW8]), e[c][i]);
            end
         end
         checks++; if (out_mask8 !== emask[c]) begin failures++; $display("FAIL directed%0d_mask got %b want %b", c, out_mask8, emask[c]); end
         checks++; if (out_mode8 !== md[c]) begin failures++; $display("FAIL directed%0d_mode got %b want %b", c, out_mode8, md[c]); end
      end
   endtask

   task automatic test_width_extremes();
      int raw [8];
      logic [N8*OW8-1:0] gd [3];
      int gcyc [3];
      int got;
      int expv;
      logic m2;
      m2 = 1'($urandom);
      for (int i = 0; i < N8; i++) raw[i] = int'($urandom_range(0, 255)) - 128;
      got = 0;
      out_ready8 = 1'b1;
      for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
         @(negedge clk);
         if (out_valid8 === 1'b1) begin gd[got] = out_data8; gcyc[got] = cyc; got++; end
         in_valid8 = (cyc < 3);
         in_mode8 = 1'b0;
         in_seg_end8 = 8'h00;
         for (int i = 0; i < N8; i++) begin
            if (cyc == 0)      in_data8[i*W8 +: W8] = 8'd127;
            else if (cyc == 1) in_data8[i*W8 +: W8] = 8'h80;
            else               in_data8[i*W8 +: W8] = 8'(raw[i]);
         end
         if (cyc == 2) begin in_seg_end8 = 8'hFF; in_mode8 = m2; end
      end
      in_valid8 = 1'b0;
      checks++; if (got != 3) begin failures++; $display("FAIL extremes_count got %0d want 3", got); end
      for (int b = 0; b < got; b++) begin
         checks++; if (gcyc[b] != b + 4) begin failures++; $display("FAIL extremes_timing beat %0d got cycle %0d want %0d", b, gcyc[b], b + 4); end
         for (int i = 0; i < N8; i++) begin
            if (b == 0)      expv = 127 * (i + 1);
            else if (b == 1) expv = -128 * (i + 1);
            else             expv = raw[i];
            checks++;
            if (gd[b][i*OW8 +: OW8] !== 11'(expv)) begin
               failures++;
               $display("FAIL extremes_b%0d_lane%0d got %0d want %0d", b, i, $signed(gd[b][i*OW8 +: OW8]), expv);
            end
         end
      end
   endtask

   task automatic test_back_pressure();
      logic [N8*W8-1:0] bd [10];
      logic [7:0] bse [10];
      beat8_t q8 [$];
      beat8_t e;
      logic [N8*OW8-1:0] hold_d;
      logic [7:0] hold_m;
      logic stalled;
      int sent, got;
      for (int b = 0; b < 10; b++) begin bd[b] = {$urandom, $urandom}; bse[b] = 8'($urandom); end
      sent = 0; got = 0; stalled = 1'b0; hold_d = '0; hold_m = '0;
      for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
         @(negedge clk);
         out_ready8 = !(cyc >= 4 && cyc <= 6);
         in_mode8 = 1'b0;
         if (sent < 10) begin
            in_valid8 = 1'b1; in_data8 = bd[sent]; in_seg_end8 = bse[sent];
         end else begin
            in_valid8 = 1'b0;
         end
         #1;
         if (out_ready8 == 1'b0) begin
            checks++; if (in_ready8 !== 1'b0 || busy8 !== 1'b1) begin failures++; $display("FAIL bp_stall_ready cyc %0d got rdy=%b busy=%b want 0/1", cyc, in_ready8, busy8); end
         end
         if (stalled) begin
            checks++;
            if (out_valid8 !== 1'b1 || out_data8 !== hold_d || out_mask8 !== hold_m) begin
               failures++; $display("FAIL bp_hold cyc %0d got vld=%b data=%h want 1 data=%h", cyc, out_valid8, out_data8, hold_d);
            end
         end
         stalled = out_valid8 && !out_ready8;
         hold_d = out_data8; hold_m = out_mask8;
         if (out_valid8 === 1'b1 && out_ready8) begin
            checks++;
            if (q8.size() == 0) begin
               failures++; $display("FAIL bp_unexpected beat got %h want none", out_data8);
            end else begin
               e = q8.pop_front();
               if (out_data8 !== e.data || out_mask8 !== e.mask || out_mode8 !== e.mode) begin
                  failures++; $display("FAIL bp_beat%0d got %h/%b want %h/%b", got, out_data8, out_mask8, e.data, e.mask);
               end
            end
            got++;
         end
         if (in_valid8 && in_ready8 === 1'b1) begin
            q8.push_back(build_exp8(in_data8, in_seg_end8, in_mode8));
            sent++;
         end
      end
      in_valid8 = 1'b0;
      out_ready8 = 1'b1;
      checks++; if (got != 10) begin failures++; $display("FAIL bp_count got %0d want 10", got); end
   endtask

   task automatic test_reset_mid_flight();
      beat8_t e;
      int lat;
      logic seen;
      out_ready8 = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         in_data8 = {$urandom, $urandom}; in_seg_end8 = 8'($urandom); in_mode8 = 1'($urandom); in_valid8 = 1'b1;
      end
      @(negedge clk);
      in_valid8 = 1'b0;
      @(negedge clk);
      checks++; if (out_valid8 !== 1'b1 || busy8 !== 1'b1) begin failures++; $display("FAIL rmf_pre got vld=%b busy=%b want 1/1", out_valid8, busy8); end
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid8 !== 1'b0 || busy8 !== 1'b0) begin failures++; $display("FAIL rmf_during got vld=%b busy=%b want 0/0", out_valid8, busy8); end
      checks++; if (in_ready8 !== 1'b1 || out_data8 !== '0) begin failures++; $display("FAIL rmf_regs got rdy=%b data=%h want 1/0", in_ready8, out_data8); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid8 !== 1'b0 || busy8 !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen) begin failures++; $display("FAIL rmf_ghost got output after reset want none"); end
      in_data8 = {$urandom, $urandom}; in_seg_end8 = 8'($urandom); in_mode8 = 1'($urandom); in_valid8 = 1'b1;
      e = build_exp8(in_data8, in_seg_end8, in_mode8);
      lat = 0;
      do begin
         @(negedge clk);
         in_valid8 = 1'b0;
         lat++;
      end while (out_valid8 !== 1'b1 && lat < 20);
      checks++; if (lat != 4) begin failures++; $display("FAIL rmf_latency got %0d want 4", lat); end
      checks++; if (out_data8 !== e.data || out_mask8 !== e.mask || out_mode8 !== e.mode) begin failures++; $display("FAIL rmf_beat got %h/%b want %h/%b", out_data8, out_mask8, e.data, e.mask); end
   endtask

   task automatic test_random32();
      localparam int NB = 10000;
      beat32_t q [$];
      beat32_t e;
      logic [N32*OW32-1:0] hold_d;
      logic [31:0] hold_m;
      logic hold_mode;
      logic stalled;
      logic [31:0] lane;
      int sent, got, bad, cyc;
      sent = 0; got = 0; stalled = 1'b0; cyc = 0;
      hold_d = '0; hold_m = '0; hold_mode = 1'b0;
      while (got < NB && cyc < 80000) begin
         @(negedge clk);
         cyc++;
         out_ready32 = ($urandom_range(0, 3) != 0);
         in_valid32 = (sent < NB) && ($urandom_range(0, 4) != 0);
         for (int i = 0; i < N32; i++) begin
            case ($urandom_range(0, 7))
               0: lane = 32'h7FFF_FFFF;
               1: lane = 32'h8000_0000;
               2: lane = 32'(int'($urandom_range(0, 15)) - 8);
               default: lane = $urandom;
            endcase
            in_data32[i*W32 +: W32] = lane;
         end
         case ($urandom_range(0, 3))
            0: in_seg_end32 = $urandom;
            1: in_seg_end32 = $urandom & $urandom & $urandom;
            2: in_seg_end32 = $urandom | $urandom;
            default: in_seg_end32 = 32'h0;
         endcase
         in_mode32 = 1'($urandom);
         #1;
         if (stalled) begin
            checks++;
            if (out_valid32 !== 1'b1 || out_data32 !== hold_d || out_mask32 !== hold_m || out_mode32 !== hold_mode) begin
               failures++; $display("FAIL rnd_hold cycle %0d got vld=%b mask=%h want 1 mask=%h", cyc, out_valid32, out_mask32, hold_m);
            end
         end
         stalled = out_valid32 && !out_ready32;
         hold_d = out_data32; hold_m = out_mask32; hold_mode = out_mode32;
         if (out_valid32 === 1'b1 && out_ready32) begin
            checks++;
            if (q.size() == 0) begin
               failures++; $display("FAIL rnd_unexpected beat %0d got mask=%h want none", got, out_mask32);
            end else begin
               e = q.pop_front();
               if (out_data32 !== e.data || out_mask32 !== e.mask || out_mode32 !== e.mode) begin
                  failures++;
                  bad = 0;
                  for (int j = N32 - 1; j >= 0; j--) if (out_data32[j*OW32 +: OW32] !== e.data[j*OW32 +: OW32]) bad = j;
                  $display("FAIL rnd_beat %0d lane %0d got %h want %h, mask got %h want %h, mode got %b want %b",
                           got, bad, out_data32[bad*OW32 +: OW32], e.data[bad*OW32 +: OW32], out_mask32, e.mask, out_mode32, e.mode);
               end
            end
            got++;
         end
         if (in_valid32 && in_ready32 === 1'b1) begin
            q.push_back(build_exp32(in_data32, in_seg_end32, in_mode32));
            sent++;
         end
      end
      in_valid32 = 1'b0;
      checks++; if (got != NB) begin failures++; $display("FAIL rnd_count got %0d want %0d", got, NB); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_directed_scans();
      test_width_extremes();
      test_back_pressure();
      test_reset_mid_flight();
      test_random32();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_reduce_pipe.md
# seg_reduce_pipe

Parametrised, pipelined segmented reduction network for the sparse-accumulation datapath. It is the next generation of the fixed 32-lane fan/reduce networks. It accepts one N-lane vector per beat, with a bitmask that cuts the vector into contiguous segments of arbitrary length. It returns per-lane inclusive segmented scans, and each segment's total (sum or signed max) is marked at the segment's last lane. It sits between the multiplier array and the output buffer, behind a valid/ready handshake, so it can absorb back-pressure.

## Interface
- N, default 32: lane count; power of two, N ≥ 2.
- W, default 32: input lane width, two's complement integer.
- LOG2N, derived = log2(N): number of scan stages.
- OW, derived = W + LOG2N: output lane width; no overflow is possible.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  N*W  lane i at bits [i*W +: W].
- in_seg_end  in  N  bit i=1 marks lane i as the last lane of a segment; bit N-1 is treated as 1 regardless.
- in_mode  in  1  0 = sum, 1 = signed max; latched per beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  N*OW  inclusive segmented scan per lane, sign-extended.
- out_mask  out  N  registered effective seg_end; lanes whose out_data is a segment total.
- out_mode  out  1  mode of the beat on the output.
- busy  out  1  any pipeline stage holds a valid beat.

## Operation
- Stage S0 captures the beat on accept (in_valid && in_ready):
  - lanes sign-extended to OW;
  - start flags f[0]=1 and f[i]=seg_end[i-1];
  - mask with bit N-1 forced to 1;
  - mode.
- Stages S1..S_LOG2N: stage k (distance d=2^(k-1)) updates every lane i ≥ d:
  - x'[i] = f[i] ? x[i] : op(x[i-d], x[i]);
  - f'[i] = f[i] | f[i-d].
  - Lanes i < d pass through unchanged.
- op is the + of OW-bit integers in sum mode, or the signed maximum in max mode.
- Mask and mode travel with their beat unchanged.
- Output register = S_LOG2N.
  - out_data[i] is the op over lanes from the segment start up to i.
  - At lanes with out_mask[i]=1, it is the full segment result.
- Single-lane segments: output equals the sign-extended input.
- Flow control uses one global advance enable: adv = !(out_valid && !out_ready).
  - When adv=1, all stages shift by one; empty stages shift in as bubbles (valid=0).
  - When adv=0, every stage holds its data and valid.
- in_ready = adv. Combinational from out_ready and out_valid only; no dependency on in_valid.
- Bubbles are not collapsed; stage count and latency are fixed.
- busy = OR of all stage valid bits.

## Timing
- Latency: a beat accepted in cycle t appears with out_valid=1 in cycle t+LOG2N+1, absent stalls.
  - Example: N=32 gives 6 cycles.
- Throughput: one beat per cycle while out_ready=1.
- Output handshake:
  - A beat leaves on the edge where out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_mask and out_mode are stable.
- Simultaneous output handshake and input accept in the same cycle is legal; both complete on that edge.
- Reset (rst_n=0, asynchronous):
  - all stage valids = 0;
  - all data, flags, mask and mode registers = 0;
  - out_valid = 0, out_data = 0, out_mask = 0, out_mode = 0, busy = 0.
  - in_ready reads 1 during and after reset.
- Reset mid-operation discards all in-flight beats; no partial output is produced after rst_n deasserts.
- Beats are delivered in order. No beat is dropped or duplicated under any out_ready pattern.

## Test plan
- Sum, N=8, W=8:
  - stimulus: data 1..8, seg_end=8'b1000_1000;
  - required: out_data = 1,3,6,10,5,11,18,26; out_mask=8'b1000_1000; out_valid in cycle t+4.
- Max, N=8:
  - stimulus: data -3,5,-1,2,-8,-7,-6,-128, seg_end=8'b0001_0100;
  - required: out_data = -3,5,5,2,2,-7,-6,-6; out_mask=8'b1001_0100 (bit 7 forced).
- Width extremes, N=8, W=8:
  - stimulus: all lanes 127 with seg_end=0, then all lanes -128;
  - required: lane 7 = 1016, then -1024, in OW=11 bits; seg_end=8'hFF returns the inputs unchanged.
- Back-pressure:
  - stimulus: stream 10 beats with in_valid=1; drop out_ready for 3 cycles while 4 beats are in flight;
  - required: in_ready=0 during the stall, output held stable, all 10 beats received in order with correct sums.
- Reset mid-flight:
  - stimulus: assert rst_n=0 with 3 beats in flight;
  - required: out_valid=0 and busy=0 immediately; no output appears after release until a new beat is accepted; that new beat appears at t+LOG2N+1.
- Random, N=32, W=32:
  - stimulus: random data, masks, modes and out_ready over 10k beats;
  - required: output matches the scoreboard model bit-exactly.
